// File: rtl/seq_buf_writer.sv
// seq_buf_writer: fills a zero-terminated sequence buffer from a valid/ready sample stream
module seq_buf_writer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] len,
    output logic              overflow,
    output logic              clamped
);
    typedef enum logic [1:0] {IDLE, WRITE, TERM, DONE} state_t;
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 2);
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              is_zero;
    // handshake and status decode straight from the state register
    always_comb begin
        in_ready = state == WRITE;
        busy     = state != IDLE;
        done     = state == DONE;
        accept   = in_valid & in_ready;
        is_zero  = in_data == '0;
    end
    // capture FSM: payload words never zero, terminator always written (address DEPTH-1 at most)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            len      <= '0;
            overflow <= 1'b0;
            clamped  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (start) begin
                        ptr      <= '0;
                        overflow <= 1'b0;
                        clamped  <= 1'b0;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en <= accept;
                    if (accept) begin
                        wr_addr <= ptr;
                        wr_data <= is_zero ? DATA_W'(1) : in_data;
                        ptr     <= ptr + 1'b1;
                        if (is_zero) clamped <= 1'b1;
                        if (in_last || ptr == PTR_MAX) begin
                            overflow <= !in_last;
                            state    <= TERM;
                        end
                    end
                end
                TERM: begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr;
                    wr_data <= '0;
                    len     <= ptr;
                    state   <= DONE;
                end
                default: begin
                    wr_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_buf_writer.sv
// tb_seq_buf_writer: scoreboard bench for the zero-terminated sequence writer
module tb_seq_buf_writer;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready, wr_en, busy, done, overflow, clamped;
    logic [ADDR_W-1:0] wr_addr, len;
    logic [DATA_W-1:0] wr_data;

    seq_buf_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .len(len), .overflow(overflow),
        .clamped(clamped)
    );

    always #5 clk = ~clk;

    // expected write-port beats: {done, addr, data}
    logic [21:0] sb[$];
    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;
    int m_len = 0;
    logic m_ovf = 1'b0;
    logic m_clamp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // every write-port beat must match the oldest expected beat
    always @(negedge clk) begin
        if (rstn && (wr_en || done)) begin
            if (sb.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
            else chk("wr_beat", 32'({wr_en, done, wr_addr, wr_data}), 32'({1'b1, sb.pop_front()}));
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l, output logic acc);
        logic [DATA_W-1:0] s;
        @(negedge clk);
        in_valid = v;
        in_data = d;
        in_last = l;
        acc = v && in_ready;
        if (acc) begin
            s = (d == 0) ? DATA_W'(1) : d;
            if (d == 0) m_clamp = 1'b1;
            sb.push_back({1'b0, ADDR_W'(m_ptr), s});
            if (l || m_ptr == DEPTH - 2) begin
                m_ovf = !l;
                m_len = m_ptr + 1;
                sb.push_back({1'b1, ADDR_W'(m_ptr + 1), DATA_W'(0)});
            end
            m_ptr++;
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        logic acc;
        int n = 0;
        do begin
            drive(1'b1, d, l, acc);
            n++;
        end while (!acc && n < 16);
        if (!acc) chk("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic begin_seq(input logic with_valid);
        @(negedge clk);
        start = 1'b1;
        in_valid = with_valid;
        in_data = 12'h555;
        in_last = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        m_ptr = 0;
        m_ovf = 1'b0;
        m_clamp = 1'b0;
    endtask

    task automatic end_seq(input string tag);
        logic acc;
        int n = 0;
        do begin
            drive(1'b0, '0, 1'b0, acc);
            n++;
        end while (!done && n < 8);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_len"}, 32'(len), 32'(m_len));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_clamp"}, 32'(clamped), 32'(m_clamp));
    endtask

    task automatic gap();
        logic acc;
        drive(1'b0, '0, 1'b0, acc);
        drive(1'b0, '0, 1'b0, acc);
        chk("gap_wren", 32'(wr_en), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_port"}, 32'({wr_en, wr_addr, wr_data}), 32'd0);
        chk({tag, "_stat"}, 32'({in_ready, busy, done, overflow, clamped}), 32'd0);
        chk({tag, "_len"}, 32'(len), 32'd0);
    endtask

    initial begin
        int acc_cnt;
        logic acc;
        #1;
        check_reset("rst0");
        @(negedge clk);
        rstn = 1'b1;
        // basic three-word sequence; the start cycle also carries an ignored sample
        begin_seq(1'b1);
        chk("write_ready", 32'(in_ready), 32'd1);
        send(12'h123, 1'b0);
        send(12'h456, 1'b0);
        send(12'h789, 1'b1);
        end_seq("basic");
        // zero sample is clamped to 1
        begin_seq(1'b0);
        send(12'h000, 1'b0);
        send(12'h0FF, 1'b1);
        end_seq("clamp");
        // overflow: 600 offered samples, only DEPTH-1 accepted
        begin_seq(1'b0);
        acc_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            drive(1'b1, 12'hABC, 1'b0, acc);
            if (acc) acc_cnt++;
        end
        chk("ovf_accepts", 32'(acc_cnt), 32'(DEPTH - 1));
        chk("ovf_stall", 32'(in_ready), 32'd0);
        chk("ovf_len", 32'(len), 32'(m_len));
        chk("ovf_flag", 32'(overflow), 32'd1);
        drive(1'b0, '0, 1'b0, acc);
        // exactly DEPTH-1 samples with last: normal end
        begin_seq(1'b0);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) send(DATA_W'(i + 7), i == DEPTH - 2);
        end_seq("full");
        // gaps in in_valid, and a start pulse during WRITE that must be ignored
        begin_seq(1'b0);
        send(12'h011, 1'b0);
        gap();
        send(12'h022, 1'b0);
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored", 32'(busy), 32'd1);
        send(12'h033, 1'b0);
        gap();
        send(12'h044, 1'b1);
        end_seq("gaps");
        // asynchronous reset mid-WRITE at ptr=5
        begin_seq(1'b0);
        send(12'h000, 1'b0);
        for (int i = 1; i < 5; i++) send(DATA_W'(i), 1'b0);
        drive(1'b0, '0, 1'b0, acc);
        #2;
        rstn = 1'b0;
        #1;
        check_reset("rst_mid");
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        begin_seq(1'b0);
        send(12'h3A5, 1'b0);
        send(12'h5A3, 1'b1);
        end_seq("after_rst");
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
